// File: rtl/uc1611_pkg.sv
// uc1611_pkg: shared FSM states, timing defaults and UC1611 command bytes
package uc1611_pkg;
  typedef enum logic [2:0] {RST_LOW, RST_WAIT, IDLE, SETUP, STROBE, HOLD} state_t;
  localparam int DEPTH_DEF = 16;
  localparam int T_SETUP_DEF = 1;
  localparam int T_PULSE_DEF = 2;
  localparam int T_HOLD_DEF = 1;
  localparam int T_RST_LOW_DEF = 1024;
  localparam int T_RST_WAIT_DEF = 4096;
  localparam logic [7:0] CMD_SYS_RESET = 8'hE2;
  localparam logic [7:0] CMD_MAPPING = 8'hC6;
  localparam logic [7:0] CMD_NOP = 8'hE3;
endpackage

// File: rtl/uc1611_bus_if.sv
// uc1611_bus_if: single-cycle byte write port from the formatter to the bus stage
interface uc1611_bus_if;
  logic [7:0] data;
  logic cd;
  logic write;
  modport master (output data, cd, write);
  modport slave (input data, cd, write);
endinterface

// File: rtl/uc1611_fifo.sv
// uc1611_fifo: synchronous FIFO with flush; one extra pointer bit separates full from empty
module uc1611_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 9
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;
  ptr_t wp, rp;
  logic [W-1:0] mem [DEPTH];
  logic wr_en;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign wr_en = push && (!full || pop) && !flush;
  assign dout = mem[rp[AW-1:0]];
  // pointer update; a flush discards any same-cycle push or pop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + ptr_t'(wr_en);
      rp <= rp + ptr_t'(pop && !empty);
    end
  // storage needs no reset: only slots behind the write pointer are ever read
  always_ff @(posedge clk)
    if (wr_en) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uc1611_bus.sv
// uc1611_bus: buffers formatter writes and replays them on the 8080 bus after panel reset
module uc1611_bus import uc1611_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD = T_HOLD_DEF,
  parameter int T_RST_LOW = T_RST_LOW_DEF,
  parameter int T_RST_WAIT = T_RST_WAIT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  uc1611_bus_if.slave fmt,
  input  logic hw_reset_req,
  input  logic ovf_clr,
  output logic ready,
  output logic overflow,
  output logic [7:0] lcd_d,
  output logic lcd_cd,
  output logic lcd_wr_n,
  output logic lcd_rd_n,
  output logic lcd_cs_n,
  output logic lcd_rst_n
);
  state_t state, state_n;
  logic [31:0] cnt, cnt_n, lim;
  logic last, pop, full, empty;
  logic [8:0] head;
  logic [7:0] nx_d;
  logic nx_cd, nx_wr, nx_cs, nx_rst, nx_ready, nx_ovf;
  uc1611_fifo #(.DEPTH(DEPTH), .W(9)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(fmt.write),
    .pop(pop),
    .flush(hw_reset_req),
    .din({fmt.cd, fmt.data}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign lcd_rd_n = 1'b1;
  assign lim = state == RST_LOW ? 32'(T_RST_LOW) : state == RST_WAIT ? 32'(T_RST_WAIT) :
               state == SETUP ? 32'(T_SETUP) : state == STROBE ? 32'(T_PULSE) : 32'(T_HOLD);
  assign last = cnt == lim - 32'd1;
  // next state and next registered bus outputs; IDLE and HOLD-end share the pop decision
  always_comb begin
    state_n = state;
    cnt_n = last ? '0 : cnt + 32'd1;
    pop = 1'b0;
    nx_d = lcd_d;
    nx_cd = lcd_cd;
    nx_wr = lcd_wr_n;
    nx_cs = lcd_cs_n;
    nx_rst = lcd_rst_n;
    nx_ready = ready;
    if (hw_reset_req) begin
      state_n = RST_LOW;
      cnt_n = '0;
      nx_rst = 1'b0;
      nx_wr = 1'b1;
      nx_cs = 1'b1;
      nx_ready = 1'b0;
    end else begin
      case (state)
        RST_LOW: if (last) begin
          state_n = RST_WAIT;
          nx_rst = 1'b1;
        end
        RST_WAIT: if (last) begin
          state_n = IDLE;
          nx_ready = 1'b1;
        end
        SETUP: if (last) begin
          state_n = STROBE;
          nx_wr = 1'b0;
        end
        STROBE: if (last) begin
          state_n = HOLD;
          nx_wr = 1'b1;
        end
        IDLE, HOLD: if (state == IDLE || last) begin
          cnt_n = '0;
          if (!empty) begin
            pop = 1'b1;
            {nx_cd, nx_d} = head;
            nx_cs = 1'b0;
            state_n = SETUP;
          end else begin
            nx_cs = 1'b1;
            state_n = IDLE;
          end
        end
      endcase
    end
    nx_ovf = (fmt.write && full && !pop && !hw_reset_req) || (overflow && !ovf_clr);
  end
  // state, counter and every bus output registered; reset drops WR and CS asynchronously
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= RST_LOW;
      cnt <= '0;
      lcd_d <= '0;
      lcd_cd <= 1'b0;
      lcd_wr_n <= 1'b1;
      lcd_cs_n <= 1'b1;
      lcd_rst_n <= 1'b0;
      ready <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      lcd_d <= nx_d;
      lcd_cd <= nx_cd;
      lcd_wr_n <= nx_wr;
      lcd_cs_n <= nx_cs;
      lcd_rst_n <= nx_rst;
      ready <= nx_ready;
      overflow <= nx_ovf;
    end
endmodule
